// File: rtl/dac_pkg.sv
// Shared types and constants for the button-driven parallel DAC controller.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_t;

    localparam int BTN_UP   = 0;
    localparam int BTN_DN   = 1;
    localparam int BTN_STEP = 2;
    localparam int BTN_CLR  = 3;

    localparam int DEF_STEP0 = 1;
    localparam int DEF_STEP1 = 4;
    localparam int DEF_STEP2 = 16;

endpackage

// File: rtl/dac_par_write.sv
// Parallel DAC write sequencer: SETUP, WR_CYCLES of strobe, HOLD, then at least one IDLE.
module dac_par_write
    import dac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dac_d,
    output logic              dac_csn,
    output logic              dac_wrn,
    output logic              busy,
    output logic              ack
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_d;
    logic              r_csn;
    logic              r_wrn;
    logic              r_busy;
    logic              w_csn_nxt;
    logic              w_wrn_nxt;

    // Pin levels are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_csn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_csn   <= w_csn_nxt;
            r_wrn   <= w_wrn_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (r_state != STROBE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (ack)
                r_d <= din;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = STROBE;
            STROBE:  if (r_cnt == CNT_LAST) w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_csn_nxt = (w_state_nxt == IDLE);
        w_wrn_nxt = (w_state_nxt != STROBE);
    end

    assign ack     = (r_state == IDLE) && req;
    assign dac_d   = r_d;
    assign dac_csn = r_csn;
    assign dac_wrn = r_wrn;
    assign busy    = r_busy;

endmodule

// File: rtl/dac_btn_ctrl.sv
// Button-driven DAC code register with saturating up/down, step select, clear,
// and a coalescing write request into the parallel DAC sequencer.
module dac_btn_ctrl
    import dac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2,
    parameter int STEP0     = DEF_STEP0,
    parameter int STEP1     = DEF_STEP1,
    parameter int STEP2     = DEF_STEP2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn_trig,
    output logic [DATA_W-1:0] value,
    output logic [1:0]        step_sel,
    output logic [DATA_W-1:0] dac_d,
    output logic              dac_csn,
    output logic              dac_wrn,
    output logic              busy
);

    logic [DATA_W-1:0] r_value;
    logic [1:0]        r_step_sel;
    logic              r_pending;
    logic [DATA_W:0]   w_step;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_up_val;
    logic [DATA_W-1:0] w_dn_val;
    logic [DATA_W-1:0] w_val_nxt;
    logic              w_changed;
    logic              w_ack;

    always_comb begin
        case (r_step_sel)
            2'd0:    w_step = (DATA_W + 1)'(STEP0);
            2'd1:    w_step = (DATA_W + 1)'(STEP1);
            default: w_step = (DATA_W + 1)'(STEP2);
        endcase
    end

    // One extra bit makes the carry-out the saturation flag.
    assign w_sum    = {1'b0, r_value} + w_step;
    assign w_up_val = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    assign w_dn_val = ({1'b0, r_value} < w_step) ? '0 : (r_value - w_step[DATA_W-1:0]);

    always_comb begin
        w_val_nxt = r_value;
        if (btn_trig[BTN_CLR])
            w_val_nxt = '0;
        else if (btn_trig[BTN_UP] && !btn_trig[BTN_DN])
            w_val_nxt = w_up_val;
        else if (btn_trig[BTN_DN] && !btn_trig[BTN_UP])
            w_val_nxt = w_dn_val;
    end

    assign w_changed = (w_val_nxt != r_value);

    // A change in the same cycle the sequencer accepts wins, so the newer code is written next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value    <= '0;
            r_step_sel <= 2'd0;
            r_pending  <= 1'b1;
        end else begin
            r_value <= w_val_nxt;
            if (btn_trig[BTN_STEP])
                r_step_sel <= (r_step_sel == 2'd2) ? 2'd0 : r_step_sel + 2'd1;
            if (w_changed)
                r_pending <= 1'b1;
            else if (w_ack)
                r_pending <= 1'b0;
        end
    end

    dac_par_write #(
        .DATA_W    (DATA_W),
        .WR_CYCLES (WR_CYCLES)
    ) u_wr (
        .clk     (clk),
        .rst     (rst),
        .req     (r_pending),
        .din     (r_value),
        .dac_d   (dac_d),
        .dac_csn (dac_csn),
        .dac_wrn (dac_wrn),
        .busy    (busy),
        .ack     (w_ack)
    );

    assign value    = r_value;
    assign step_sel = r_step_sel;

endmodule

// File: tb/tb_dac_btn_ctrl.sv
// Directed bench for dac_btn_ctrl with a cycle-level behavioural model of the write frame.
module tb_dac_btn_ctrl;

    localparam int DW  = 8;
    localparam int WR  = 2;
    localparam int MAXV = (1 << DW) - 1;
    localparam logic [3:0] B_UP   = 4'b0001;
    localparam logic [3:0] B_DN   = 4'b0010;
    localparam logic [3:0] B_STEP = 4'b0100;
    localparam logic [3:0] B_CLR  = 4'b1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    btn_trig;
    logic [DW-1:0] value;
    logic [1:0]    step_sel;
    logic [DW-1:0] dac_d;
    logic          dac_csn;
    logic          dac_wrn;
    logic          busy;

    int checks = 0;
    int errors = 0;

    dac_btn_ctrl #(
        .DATA_W    (DW),
        .WR_CYCLES (WR),
        .STEP0     (1),
        .STEP1     (4),
        .STEP2     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_trig (btn_trig),
        .value    (value),
        .step_sel (step_sel),
        .dac_d    (dac_d),
        .dac_csn  (dac_csn),
        .dac_wrn  (dac_wrn),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase -1 is idle, 0 is setup, 1..WR strobe, WR+1 hold.
    int m_val, m_step_sel, m_d, m_phase, m_next;
    bit m_pend;
    bit m_valid = 1'b0;

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 4 : 16;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_step_sel = 0; m_d = 0; m_phase = -1; m_pend = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_phase < 0) begin
                if (m_pend) begin
                    m_phase = 0; m_d = m_val; m_pend = 1'b0;
                end
            end else if (m_phase >= WR + 1) begin
                m_phase = -1;
            end else begin
                m_phase++;
            end
            m_next = m_val;
            if (btn_trig[3])
                m_next = 0;
            else if (btn_trig[0] && !btn_trig[1])
                m_next = (m_val + step_of(m_step_sel) > MAXV) ? MAXV : m_val + step_of(m_step_sel);
            else if (btn_trig[1] && !btn_trig[0])
                m_next = (m_val - step_of(m_step_sel) < 0) ? 0 : m_val - step_of(m_step_sel);
            if (m_next != m_val) m_pend = 1'b1;
            m_val = m_next;
            if (btn_trig[2]) m_step_sel = (m_step_sel + 1) % 3;
        end
    end

    // Compare every cycle and log each strobe's data bus.
    logic [DW-1:0] wr_log[$];
    logic prev_wrn = 1'b1;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("value",    32'(value),    m_val);
            chk("step_sel", 32'(step_sel), m_step_sel);
            chk("dac_d",    32'(dac_d),    m_d);
            chk("dac_csn",  32'(dac_csn),  (m_phase < 0) ? 1 : 0);
            chk("dac_wrn",  32'(dac_wrn),  (m_phase >= 1 && m_phase <= WR) ? 0 : 1);
            chk("busy",     32'(busy),     (m_phase >= 0) ? 1 : 0);
        end
        if (prev_wrn === 1'b1 && dac_wrn === 1'b0) wr_log.push_back(dac_d);
        prev_wrn = dac_wrn;
    end

    task automatic pulse(input logic [3:0] b);
        btn_trig = b;
        @(negedge clk);
        btn_trig = 4'b0000;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_phase < 0 && !m_pend) && n < 60);
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: write sequence did not settle within 60 cycles");
        end
    endtask

    int base;

    initial begin
        rst = 1'b1;
        btn_trig = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Initial write of zero after reset
        wait_idle();
        chk("init_writes", wr_log.size(), 1);
        chk("init_data", wr_log[0], 0);
        chk("init_busy", busy, 0);

        // Up with step 1: value next cycle, SETUP two cycles after the pulse
        base = wr_log.size();
        btn_trig = B_UP;
        @(negedge clk);
        btn_trig = 4'b0000;
        chk("up_value_n1", value, 8'h01);
        chk("up_csn_n1", dac_csn, 1);
        @(negedge clk);
        chk("up_csn_setup", dac_csn, 0);
        chk("up_wrn_setup", dac_wrn, 1);
        @(negedge clk);
        chk("up_wrn_strobe", dac_wrn, 0);
        chk("up_d_strobe", dac_d, 8'h01);
        wait_idle();
        chk("up_writes", wr_log.size() - base, 1);

        // Build 0xF5 at step 16 then step 1, saturate up
        pulse(B_CLR);
        pulse(B_STEP); pulse(B_STEP);
        repeat (15) pulse(B_UP);
        pulse(B_STEP);
        repeat (5) pulse(B_UP);
        pulse(B_STEP); pulse(B_STEP);
        wait_idle();
        chk("sat_pre_value", value, 8'hF5);
        chk("sat_pre_step", step_sel, 2);
        base = wr_log.size();
        pulse(B_UP);
        wait_idle();
        chk("sat_value", value, 8'hFF);
        chk("sat_writes", wr_log.size() - base, 1);
        chk("sat_data", wr_log[base], 8'hFF);
        base = wr_log.size();
        pulse(B_UP);
        wait_idle();
        chk("sat_noop_value", value, 8'hFF);
        chk("sat_noop_writes", wr_log.size() - base, 0);

        // Step 4, value 3, down clamps to zero
        pulse(B_STEP);
        pulse(B_CLR);
        repeat (3) pulse(B_UP);
        pulse(B_STEP);
        wait_idle();
        chk("dn_pre_value", value, 8'h03);
        chk("dn_pre_step", step_sel, 1);
        base = wr_log.size();
        pulse(B_DN);
        wait_idle();
        chk("dn_value", value, 8'h00);
        chk("dn_writes", wr_log.size() - base, 1);
        chk("dn_data", wr_log[base], 8'h00);
        base = wr_log.size();
        pulse(B_DN);
        wait_idle();
        chk("dn_noop_writes", wr_log.size() - base, 0);

        // Three ups during a write of 0x05 coalesce into one write of 0x08
        pulse(B_STEP); pulse(B_STEP);
        repeat (4) pulse(B_UP);
        wait_idle();
        base = wr_log.size();
        btn_trig = B_UP;
        @(negedge clk);
        btn_trig = 4'b0000;
        @(negedge clk);
        chk("coal_setup_csn", dac_csn, 0);
        btn_trig = B_UP;
        repeat (3) @(negedge clk);
        btn_trig = 4'b0000;
        wait_idle();
        chk("coal_writes", wr_log.size() - base, 2);
        chk("coal_first", wr_log[base], 8'h05);
        chk("coal_second", wr_log[base + 1], 8'h08);

        // Up and down together: no change
        base = wr_log.size();
        pulse(B_UP | B_DN);
        wait_idle();
        chk("updn_value", value, 8'h08);
        chk("updn_writes", wr_log.size() - base, 0);

        // Clear overrides up at 0x40
        pulse(B_STEP); pulse(B_STEP);
        pulse(B_CLR);
        repeat (4) pulse(B_UP);
        wait_idle();
        chk("clr_pre_value", value, 8'h40);
        pulse(B_CLR | B_UP);
        chk("clr_value", value, 8'h00);
        wait_idle();

        // Reset during strobe aborts the frame, then a fresh write of zero
        base = wr_log.size();
        btn_trig = B_UP;
        @(negedge clk);
        btn_trig = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_strobe", dac_wrn, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_csn", dac_csn, 1);
        chk("rst_wrn", dac_wrn, 1);
        chk("rst_value", value, 8'h00);
        chk("rst_step", step_sel, 0);
        rst = 1'b0;
        wait_idle();
        chk("rst_writes", wr_log.size() - base, 2);
        chk("rst_aborted", wr_log[base], 8'h10);
        chk("rst_rewrite", wr_log[base + 1], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
